muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer sitting beside the single-cycle ALU in execute. The core decodes an M-extension instruction, stalls, and hands operands to this block over a valid/ready request channel. The block runs a 32-step shift-add or restoring-divide loop and returns one 32-bit result over a valid/ready response channel. Fixed latency is 35 cycles; the divide-by-zero short path takes 2 cycles.

---
 rtl/muldiv_seq_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_seq.sv | 174 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// operand width, RV32M funct3 op codes, FSM state encoding and sign helpers.
package muldiv_seq_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef logic [2:0] md_state_t;

  localparam md_state_t ST_IDLE = 3'd0;
  localparam md_state_t ST_PREP = 3'd1;
  localparam md_state_t ST_CALC = 3'd2;
  localparam md_state_t ST_FIX  = 3'd3;
  localparam md_state_t ST_DONE = 3'd4;

  function automatic logic src1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic src2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: 33-bit conditional add for multiply, or a
// restoring trial subtract for divide that also yields the quotient bit.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic            i_div,
  input  logic            i_add_en,
  input  logic [XLEN:0]   i_acc,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN:0]   o_acc,
  output logic            o_qbit
);

  logic [XLEN+1:0] w_diff;
  logic            w_fits;

  always_comb begin
    // Extra top bit acts as the borrow of the trial subtraction.
    w_diff = {1'b0, i_acc} - {2'b00, i_opnd};
    w_fits = ~w_diff[XLEN+1];
    o_qbit = 1'b0;
    o_acc  = i_acc;
    if (i_div) begin
      o_qbit = w_fits;
      if (w_fits) begin
        o_acc = w_diff[XLEN:0];
      end
    end else if (i_add_en) begin
      o_acc = i_acc + {1'b0, i_opnd};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: valid/ready request, 32-step iterative
// loop, sign fix-up, valid/ready response. 35-cycle latency, 2 for div-by-zero.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  md_state_t       r_state, w_state_nxt;
  logic [2:0]      r_op, w_op_nxt;
  logic [XLEN-1:0] r_src1, w_src1_nxt;
  logic [XLEN-1:0] r_src2, w_src2_nxt;
  logic            r_neg_q, w_neg_q_nxt;
  logic            r_neg_r, w_neg_r_nxt;
  logic [4:0]      r_cnt, w_cnt_nxt;
  logic [XLEN:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0] r_lo, w_lo_nxt;
  logic [XLEN-1:0] r_b, w_b_nxt;
  logic [XLEN-1:0] r_opnd, w_opnd_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;

  logic            w_is_div;
  logic            w_sign1, w_sign2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  logic [XLEN:0]   w_step_in, w_step_out;
  logic            w_step_qbit;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix;

  assign w_is_div = r_op[2];
  assign w_sign1  = src1_signed(r_op) & r_src1[XLEN-1];
  assign w_sign2  = src2_signed(r_op) & r_src2[XLEN-1];
  assign w_mag1   = w_sign1 ? (~r_src1 + 1'b1) : r_src1;
  assign w_mag2   = w_sign2 ? (~r_src2 + 1'b1) : r_src2;

  // Divide shifts the next dividend bit into the partial remainder first.
  assign w_step_in = w_is_div ? {r_acc[XLEN-1:0], r_lo[XLEN-1]} : r_acc;

  muldiv_step u_step (
    .i_div    (w_is_div),
    .i_add_en (r_b[0]),
    .i_acc    (w_step_in),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_out),
    .o_qbit   (w_step_qbit)
  );

  assign w_prod     = {r_acc[XLEN-1:0], r_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_fix  = r_neg_r ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_src1_nxt   = r_src1;
    w_src2_nxt   = r_src2;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_lo_nxt     = r_lo;
    w_b_nxt      = r_b;
    w_opnd_nxt   = r_opnd;
    w_result_nxt = r_result;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_PREP;
          w_op_nxt    = req_op;
          w_src1_nxt  = req_src1;
          w_src2_nxt  = req_src2;
        end
      end
      ST_PREP: begin
        w_neg_q_nxt = (r_op == MD_MULHSU) ? w_sign1 : (w_sign1 ^ w_sign2);
        w_neg_r_nxt = w_is_div & w_sign1;
        w_acc_nxt   = '0;
        w_cnt_nxt   = 5'd31;
        // Multiply: opnd = multiplicand, b = multiplier. Divide: lo = dividend, opnd = divisor.
        w_opnd_nxt  = w_is_div ? w_mag2 : w_mag1;
        w_b_nxt     = w_mag2;
        w_lo_nxt    = w_is_div ? w_mag1 : '0;
        if (w_is_div && (r_src2 == '0)) begin
          w_result_nxt = r_op[1] ? r_src1 : '1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_is_div) begin
          w_acc_nxt = w_step_out;
          w_lo_nxt  = {r_lo[XLEN-2:0], w_step_qbit};
        end else begin
          w_acc_nxt = {1'b0, w_step_out[XLEN:1]};
          w_lo_nxt  = {w_step_out[0], r_lo[XLEN-1:1]};
          w_b_nxt   = {1'b0, r_b[XLEN-1:1]};
        end
        w_cnt_nxt = r_cnt - 5'd1;
        if (r_cnt == 5'd0) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        if (w_is_div) begin
          w_result_nxt = r_op[1] ? w_rem_fix : w_quo_fix;
        end else begin
          w_result_nxt = (r_op == MD_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        end
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Flush wins over everything, including a response handshake.
    if (kill && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_opnd   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_src1   <= w_src1_nxt;
      r_src2   <= w_src2_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_lo     <= w_lo_nxt;
      r_b      <= w_b_nxt;
      r_opnd   <= w_opnd_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_data  = resp_valid ? r_result : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, div-by-zero, backpressure,
// kill and asynchronous reset, all against hand-computed expectations.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resp_valid && resp_ready) hs_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Issue one request and wait for the response; lat is the cycle number of
  // the first cycle with resp_valid (accept edge = 0), -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] data, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_src1   = a;
    req_src2   = b;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_src1  = 32'hDEAD_BEEF;
    req_src2  = 32'h0BAD_F00D;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    data = resp_data;
    if (!resp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'b000;
    req_src1   = '0;
    req_src2   = '0;
    kill       = 1'b0;
    resp_ready = 1'b1;
    #12;
    n_vec++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b required 100", {req_ready, resp_valid, busy});
    end
    n_vec++;
    if (resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 00000000", resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  op  [4] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU};
    logic [31:0] a   [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(op[i], a[i], b[i], d, lat);
      n_vec++;
      if (d !== exp[i]) begin
        n_fail++;
        $display("FAIL mul_%0d op=%b: got %h required %h", i, op[i], d, exp[i]);
      end
      n_vec++;
      if (lat !== 35) begin
        n_fail++;
        $display("FAIL mul_lat_%0d: got cycle %0d required 35", i, lat);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op  [4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
    logic [31:0] a   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] d;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(op[i], a[i], b[i], d, lat);
      n_vec++;
      if (d !== exp[i]) begin
        n_fail++;
        $display("FAIL div_%0d op=%b: got %h required %h", i, op[i], d, exp[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    int lat;
    run_op(MD_DIVU, 32'd5, 32'd0, d, lat);
    n_vec++;
    if (d !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_by_zero: got %h required ffffffff", d);
    end
    n_vec++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL divu_by_zero_lat: got cycle %0d required 2", lat);
    end
    run_op(MD_REM, 32'd5, 32'd0, d, lat);
    n_vec++;
    if (d !== 32'd5) begin
      n_fail++;
      $display("FAIL rem_by_zero: got %h required 00000005", d);
    end
    n_vec++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL rem_by_zero_lat: got cycle %0d required 2", lat);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int lat;
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, d, lat);
    n_vec++;
    if (d !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: got %h required 80000000", d);
    end
    n_vec++;
    if (lat !== 35) begin
      n_fail++;
      $display("FAIL div_overflow_lat: got cycle %0d required 35", lat);
    end
    run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, d, lat);
    n_vec++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL rem_overflow: got %h required 00000000", d);
    end
    n_vec++;
    if (lat !== 35) begin
      n_fail++;
      $display("FAIL rem_overflow_lat: got cycle %0d required 35", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int lat;
    run_op(MD_DIVU, 32'd9, 32'd0, d, lat);
    @(negedge clk);
    n_vec++;
    if ({req_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_ready: got rdy/busy=%b required 10", {req_ready, busy});
    end
    run_op(MD_MUL, 32'd6, 32'd7, d, lat);
    n_vec++;
    if (d !== 32'd42) begin
      n_fail++;
      $display("FAIL b2b_mul: got %h required 0000002a", d);
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    int wait_cyc = 0;
    int bad = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = MD_MULHU;
    req_src1   = 32'hFFFF_FFFF;
    req_src2   = 32'hFFFF_FFFF;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    // Keep a second request pending to show DONE never accepts it.
    req_op   = MD_MUL;
    req_src1 = 32'd1;
    req_src2 = 32'd1;
    while (!resp_valid && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    hs0 = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (!resp_valid || req_ready || resp_data !== 32'hFFFF_FFFE) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles required 0 (data %h)", bad, resp_data);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got vld/rdy=%b required 01", {resp_valid, req_ready});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (hs_cnt - hs0 != 1) begin
      n_fail++;
      $display("FAIL bp_handshakes: got %0d required 1", hs_cnt - hs0);
    end
  endtask

  task automatic test_kill();
    logic [31:0] d;
    int lat;
    int seen = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = MD_MUL;
    req_src1   = 32'h1234_5678;
    req_src2   = 32'd9;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_vec++;
    if ({busy, req_ready, resp_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL kill_idle: got busy/rdy/vld=%b required 010", {busy, req_ready, resp_valid});
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL kill_no_resp: got %0d resp cycles required 0", seen);
    end
    run_op(MD_MUL, 32'd3, 32'd4, d, lat);
    n_vec++;
    if (d !== 32'd12) begin
      n_fail++;
      $display("FAIL kill_then_mul: got %h required 0000000c", d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = MD_MULHU;
    req_src1  = 32'hFFFF_FFFF;
    req_src2  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_rst_flags: got rdy/vld/busy=%b required 100",
               {req_ready, resp_valid, busy});
    end
    n_vec++;
    if (resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_rst_data: got %h required 00000000", resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_DIVU, 32'd100, 32'd7, d, lat);
    n_vec++;
    if (d !== 32'd14) begin
      n_fail++;
      $display("FAIL post_reset_divu: got %h required 0000000e", d);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_kill();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
